vlsu_beat_seq: RTL and testbench

VLSU_BEAT_SEQ -- requirements
Module: vlsu_beat_seq

---
 rtl/vlsu_beat_seq.sv | 111 +++++++++++
 tb/tb_vlsu_beat_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_beat_seq.sv
// Vector load/store beat sequencer: splits one VLEN-wide memory operation into
// 64-bit beat requests, gathers the in-order responses and reports completion.
module vlsu_beat_seq #(
    parameter int VLEN = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_store,
    input  logic [VLEN/64-1:0][63:0] req_addrs,
    input  logic [VLEN-1:0]          req_wdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [63:0]              mem_req_addr,
    output logic                     mem_req_we,
    output logic [63:0]              mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [63:0]              mem_resp_rdata,
    output logic                     done_valid,
    output logic [VLEN-1:0]          done_rdata,
    input  logic                     done_ready
);

    localparam int NBEATS = VLEN / 64;
    localparam int CW     = $clog2(NBEATS) + 1;
    localparam int IW     = CW - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [NBEATS-1:0][63:0] addrs_q;
    logic [NBEATS-1:0][63:0] wdata_q;
    logic [NBEATS-1:0][63:0] lbuf;
    logic                    is_store_q;
    logic [CW-1:0]           iss_cnt, resp_cnt, resp_cnt_nxt;
    logic [IW-1:0]           iss_idx, resp_idx;
    logic                    accept, req_fire, resp_fire, last_beat;

    assign accept    = (state == IDLE) && req_valid;
    assign req_fire  = (state == ISSUE) && mem_req_ready;
    // The outstanding window includes the beat being handed over this cycle,
    // so a zero-latency response is counted alongside its own request.
    assign resp_fire = ((state == ISSUE) || (state == DRAIN)) && mem_resp_valid &&
                       (resp_cnt < iss_cnt + CW'(req_fire));

    assign resp_cnt_nxt = resp_cnt + CW'(resp_fire);
    assign last_beat    = (iss_cnt == CW'(NBEATS - 1));
    assign iss_idx      = iss_cnt[IW-1:0];
    assign resp_idx     = resp_cnt[IW-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: assigning a default first keeps combinational blocks free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ISSUE;
            ISSUE:   if (req_fire && last_beat)
                         state_nxt = (resp_cnt_nxt == CW'(NBEATS)) ? DONE : DRAIN;
            DRAIN:   if (resp_cnt_nxt == CW'(NBEATS)) state_nxt = DONE;
            DONE:    if (done_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the beat buffers are reset too, since done_rdata and the latched fields must read zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrs_q    <= '0;
            wdata_q    <= '0;
            lbuf       <= '0;
            is_store_q <= 1'b0;
            iss_cnt    <= '0;
            resp_cnt   <= '0;
        end else if (accept) begin
            addrs_q    <= req_addrs;
            wdata_q    <= req_wdata;
            is_store_q <= req_is_store;
            lbuf       <= '0;
            iss_cnt    <= '0;
            resp_cnt   <= '0;
        end else begin
            // Both counters stop at NBEATS: issue ends with the last beat and
            // responses are never accepted beyond what has been issued.
            if (req_fire) iss_cnt <= iss_cnt + CW'(1);
            if (resp_fire) begin
                resp_cnt <= resp_cnt_nxt;
                if (!is_store_q) lbuf[resp_idx] <= mem_resp_rdata;
            end
        end
    end

    always_comb begin
        req_ready     = (state == IDLE);
        mem_req_valid = (state == ISSUE);
        mem_req_we    = (state == ISSUE) && is_store_q;
        mem_req_addr  = (state == ISSUE) ? addrs_q[iss_idx] : 64'd0;
        mem_req_wdata = ((state == ISSUE) && is_store_q) ? wdata_q[iss_idx] : 64'd0;
        done_valid    = (state == DONE);
        done_rdata    = (state == DONE) ? lbuf : '0;
    end

endmodule

// File: tb/tb_vlsu_beat_seq.sv
// Self-checking bench for vlsu_beat_seq: directed scenarios plus randomized
// operations checked against a transaction-level model of the beat protocol.
`timescale 1ns/1ps
module tb_vlsu_beat_seq;

    localparam int VLEN   = 256;
    localparam int NBEATS = VLEN / 64;
    localparam int BUDGET = 200;
    localparam int RW     = 3 + 64 + 64 + 1 + VLEN;

    typedef logic [NBEATS-1:0][63:0] beats_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, req_is_store;
    beats_t          req_addrs;
    logic [VLEN-1:0] req_wdata;
    logic            mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0]     mem_req_addr, mem_req_wdata;
    logic            mem_resp_valid;
    logic [63:0]     mem_resp_rdata;
    logic            done_valid, done_ready;
    logic [VLEN-1:0] done_rdata;

    int n_cmp = 0;
    int n_err = 0;

    vlsu_beat_seq #(.VLEN(VLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addrs(req_addrs), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .done_valid(done_valid), .done_rdata(done_rdata), .done_ready(done_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic beats_t rand_beats();
        beats_t b;
        for (int i = 0; i < NBEATS; i++) b[i] = rand64();
        return b;
    endfunction

    // One complete operation: accept, beat issue, responses, completion.
    // The model tracks only beats issued and responses returned.
    task automatic run_op(input string name, input logic is_store, input beats_t addrs,
                          input logic [VLEN-1:0] wdata, input beats_t rdata,
                          input int ready_mode, input int resp_delay, input int done_hold,
                          input bit stray_en, input bit hold_valid, output int done_cycle);
        int              issued, delivered, held, d;
        int              due_q[$];
        bit              rdy, hs, exp_done, finished;
        logic [VLEN-1:0] exp_rdata;
        logic [63:0]     exp_wd;
        beats_t          tmp;

        tmp        = rdata;
        exp_rdata  = is_store ? '0 : tmp;
        issued     = 0;
        delivered  = 0;
        held       = 0;
        done_cycle = -1;
        finished   = 1'b0;

        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept_ready: got %b expected 1", name, req_ready);
        end
        req_valid      = 1'b1;
        req_is_store   = is_store;
        req_addrs      = addrs;
        req_wdata      = wdata;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        done_ready     = 1'b0;

        for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
            @(negedge clk);
            exp_done = (delivered == NBEATS);
            if (hold_valid) begin
                req_valid    = 1'b1;
                req_is_store = 1'($urandom);
                req_addrs    = rand_beats();
                req_wdata    = rand_beats();
            end else begin
                req_valid = 1'b0;
            end

            n_cmp++;
            if (req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy_ready cyc%0d: got %b expected 0", name, cyc, req_ready);
            end
            n_cmp++;
            if (mem_req_valid !== (issued < NBEATS)) begin
                n_err++;
                $display("FAIL %s mem_req_valid cyc%0d: got %b expected %b", name, cyc,
                         mem_req_valid, (issued < NBEATS));
            end
            n_cmp++;
            if (done_valid !== exp_done) begin
                n_err++;
                $display("FAIL %s done_valid cyc%0d: got %b expected %b", name, cyc, done_valid, exp_done);
            end
            if (issued < NBEATS) begin
                exp_wd = is_store ? wdata[64*issued +: 64] : 64'd0;
                n_cmp++;
                if ({mem_req_addr, mem_req_we, mem_req_wdata} !== {addrs[issued], is_store, exp_wd}) begin
                    n_err++;
                    $display("FAIL %s beat%0d_payload cyc%0d: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                             name, issued, cyc, mem_req_addr, mem_req_we, mem_req_wdata,
                             addrs[issued], is_store, exp_wd);
                end
            end
            if (exp_done) begin
                n_cmp++;
                if (done_rdata !== exp_rdata) begin
                    n_err++;
                    $display("FAIL %s done_rdata cyc%0d: got %h expected %h", name, cyc, done_rdata, exp_rdata);
                end
                if (done_cycle < 0) done_cycle = cyc;
            end

            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 2) == 1);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            mem_req_ready = rdy;
            hs = (issued < NBEATS) && rdy;
            if (hs) begin
                d = (resp_delay < 0) ? int'($urandom_range(0, 4)) : resp_delay;
                due_q.push_back(cyc + d);
                issued++;
            end

            mem_resp_valid = 1'b0;
            mem_resp_rdata = rand64();
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = rdata[delivered];
                void'(due_q.pop_front());
                delivered++;
            end else if (stray_en && !hs && due_q.size() == 0 && $urandom_range(0, 2) == 0) begin
                mem_resp_valid = 1'b1;  // nothing outstanding, so this must be ignored
            end

            done_ready = 1'b0;
            if (exp_done) begin
                if (held >= done_hold) begin
                    done_ready = 1'b1;
                    finished   = 1'b1;
                end else begin
                    held++;
                end
            end
        end

        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got issued=%0d responses=%0d expected completion within %0d cycles",
                     name, issued, delivered, BUDGET);
        end
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        done_ready     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        req_valid      = 1'b1;
        req_is_store   = 1'b1;
        req_addrs      = rand_beats();
        req_wdata      = rand_beats();
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rand64();
        done_ready     = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, done_valid, done_rdata}
            !== {1'b1, {(RW - 1){1'b0}}}) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b valid=%b we=%b addr=%h wdata=%h done=%b rdata=%h expected ready=1 rest 0",
                     req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, done_valid, done_rdata);
        end
        req_valid      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        rst_n          = 1'b1;
    endtask

    task automatic test_unit_load();
        beats_t addrs, rdata;
        int     dc;
        for (int i = 0; i < NBEATS; i++) begin
            addrs[i] = 64'h1000 + 64'(8 * i);
            rdata[i] = 64'hA0 + 64'(i);
        end
        run_op("unit_load", 1'b0, addrs, '0, rdata, 0, 0, 0, 1'b0, 1'b0, dc);
        n_cmp++;
        if (dc !== NBEATS + 1) begin
            n_err++;
            $display("FAIL unit_load latency: got done on cycle %0d expected %0d", dc, NBEATS + 1);
        end
    endtask

    task automatic test_store_toggle();
        logic [VLEN-1:0] wdata;
        int              dc;
        wdata = {64'h44, 64'h33, 64'h22, 64'h11};
        run_op("store_toggle", 1'b1, rand_beats(), wdata, rand_beats(), 1, 0, 0, 1'b0, 1'b0, dc);
        n_cmp++;
        if (dc !== 2 * NBEATS) begin
            n_err++;
            $display("FAIL store_toggle latency: got done on cycle %0d expected %0d", dc, 2 * NBEATS);
        end
    endtask

    task automatic test_delayed_resp();
        int dc;
        run_op("delayed_resp", 1'b0, rand_beats(), '0, rand_beats(), 0, 3, 0, 1'b0, 1'b0, dc);
        n_cmp++;
        if (dc !== NBEATS + 4) begin
            n_err++;
            $display("FAIL delayed_resp latency: got done on cycle %0d expected %0d", dc, NBEATS + 4);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        run_op("backpressure", 1'b0, rand_beats(), '0, rand_beats(), 0, 0, 5, 1'b0, 1'b1, dc);
        run_op("after_backpressure", 1'b1, rand_beats(), rand_beats(), rand_beats(), 0, 1, 0, 1'b0, 1'b0, dc);
    endtask

    task automatic test_reset_mid_issue();
        beats_t addrs;
        int     dc;
        addrs = rand_beats();
        @(negedge clk);
        req_valid     = 1'b1;
        req_is_store  = 1'b0;
        req_addrs     = addrs;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            req_valid      = 1'b0;
            mem_req_ready  = (b < 2);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rand64();
            n_cmp++;
            if ({mem_req_valid, mem_req_addr} !== {1'b1, addrs[b]}) begin
                n_err++;
                $display("FAIL rst_mid beat%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                         b, mem_req_valid, mem_req_addr, addrs[b]);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, done_valid, done_rdata}
            !== {1'b1, {(RW - 1){1'b0}}}) begin
            n_err++;
            $display("FAIL rst_mid async_outputs: got ready=%b valid=%b addr=%h done=%b expected ready=1 rest 0",
                     req_ready, mem_req_valid, mem_req_addr, done_valid);
        end
        req_valid     = 1'b1;
        mem_req_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({req_ready, mem_req_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL rst_mid held: got ready=%b valid=%b expected ready=1 valid=0", req_ready, mem_req_valid);
            end
        end
        req_valid      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        rst_n          = 1'b1;
        run_op("load_after_reset", 1'b0, rand_beats(), '0, rand_beats(), 2, -1, 1, 1'b0, 1'b0, dc);
    endtask

    task automatic test_stray_resp();
        int dc;
        repeat (3) begin
            @(negedge clk);
            req_valid      = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rand64();
            n_cmp++;
            if ({req_ready, mem_req_valid, done_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL stray_idle: got ready=%b valid=%b done=%b expected ready=1 valid=0 done=0",
                         req_ready, mem_req_valid, done_valid);
            end
        end
        run_op("stray_load", 1'b0, rand_beats(), '0, rand_beats(), 2, -1, 2, 1'b1, 1'b0, dc);
    endtask

    task automatic test_random();
        int dc;
        for (int n = 0; n < 30; n++) begin
            run_op("random", 1'($urandom), rand_beats(), rand_beats(), rand_beats(),
                   int'($urandom_range(0, 2)), -1, int'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), dc);
        end
    endtask

    initial begin
        test_reset();
        test_unit_load();
        test_store_toggle();
        test_delayed_resp();
        test_back_to_back();
        test_reset_mid_issue();
        test_stray_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
